// File: rtl/frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : frame_serializer
// Purpose  : Serialises a payload word as sync + MSB-first payload + optional
//            even parity, followed by a programmable zero gap.
// Revision : 1.0 - initial release
// ============================================================================
module frame_serializer #(
    parameter int                 DATA_W    = 8,
    parameter int                 SYNC_W    = 4,
    parameter logic [SYNC_W-1:0]  SYNC_PAT  = 4'b1010,
    parameter int                 PARITY_EN = 1,
    parameter int                 GAP       = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              OUT_DATA,
    output logic              OUT_VALID,
    output logic              FRAME_START,
    output logic              BUSY
);

    localparam int c_FRAME_W = SYNC_W + DATA_W + ((PARITY_EN != 0) ? 1 : 0);
    localparam int c_CNT_MAX = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_SYNC_LAST = c_CNT_W'(SYNC_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [7:0]         c_GAP_LAST  = 8'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_SYNC = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_PAR  = 3'd3;
    localparam logic [2:0] c_GAP  = 3'd4;

    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_gap_cnt;
    logic [c_FRAME_W-1:0] r_shift;
    logic                 r_ready;
    logic                 r_out_data;
    logic                 r_out_valid;
    logic                 r_frame_start;
    logic                 r_busy;

    logic [c_FRAME_W-1:0] w_frame;
    logic                 w_accept;
    logic                 w_eof;
    logic                 w_to_last;

    // The whole frame (sync, payload, parity) is loaded as one shift image.
    if (PARITY_EN != 0) begin : g_par
        assign w_frame = {SYNC_PAT, DIN, ^DIN};
    end else begin : g_nopar
        assign w_frame = {SYNC_PAT, DIN};
    end

    assign w_accept = DIN_VALID & r_ready;

    always_comb begin
        w_eof     = (r_state == c_PAR) ||
                    ((r_state == c_DATA) && (r_cnt == '0) && (PARITY_EN == 0));
        w_to_last = 1'b0;
        // With no gap, ready is raised while the final frame bit is on the line.
        if (GAP == 0) begin
            if (PARITY_EN != 0) begin
                w_to_last = (r_state == c_DATA) && (r_cnt == '0);
            end else begin
                w_to_last = ((r_state == c_DATA) && (r_cnt == c_CNT_ONE)) ||
                            ((r_state == c_SYNC) && (r_cnt == '0) && (DATA_W == 1));
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_gap_cnt     <= '0;
            r_shift       <= '0;
            r_ready       <= 1'b0;
            r_out_data    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_accept && ((r_state == c_IDLE) || w_eof)) begin
                r_state       <= c_SYNC;
                r_cnt         <= c_SYNC_LAST;
                r_shift       <= w_frame << 1;
                r_out_data    <= w_frame[c_FRAME_W-1];
                r_out_valid   <= 1'b1;
                r_frame_start <= 1'b1;
                r_busy        <= 1'b1;
                r_ready       <= 1'b0;
            end else if (w_eof) begin
                r_out_data  <= 1'b0;
                r_out_valid <= 1'b0;
                r_cnt       <= '0;
                if (GAP > 0) begin
                    r_state   <= c_GAP;
                    r_gap_cnt <= c_GAP_LAST;
                    r_busy    <= 1'b1;
                    r_ready   <= 1'b0;
                end else begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_ready <= 1'b1;
                    end
                    c_SYNC, c_DATA: begin
                        r_out_data <= r_shift[c_FRAME_W-1];
                        r_shift    <= r_shift << 1;
                        r_ready    <= w_to_last;
                        if (r_cnt == '0) begin
                            if (r_state == c_SYNC) begin
                                r_state <= c_DATA;
                                r_cnt   <= c_DATA_LAST;
                            end else begin
                                r_state <= c_PAR;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_GAP: begin
                        if (r_gap_cnt == '0) begin
                            r_state <= c_IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= c_IDLE;
                        r_out_data  <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DIN_READY   = r_ready;
    assign OUT_DATA    = r_out_data;
    assign OUT_VALID   = r_out_valid;
    assign FRAME_START = r_frame_start;
    assign BUSY        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_serializer
// Purpose  : Scoreboard bench for frame_serializer (default and gapless builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default build: parity on, gap of 2
    logic       rstn, din_valid, din_ready, out_data, out_valid, frame_start, busy;
    logic [7:0] din;
    // Gapless build: parity off, gap of 0
    logic       b_rstn, b_valid, b_ready, b_out_data, b_out_valid, b_frame_start, b_busy;
    logic [7:0] b_din;

    frame_serializer u_dut_a (
        .CLK(clk), .RSTN(rstn), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready),
        .OUT_DATA(out_data), .OUT_VALID(out_valid), .FRAME_START(frame_start), .BUSY(busy)
    );

    frame_serializer #(.GAP(0), .PARITY_EN(0)) u_dut_b (
        .CLK(clk), .RSTN(b_rstn), .DIN(b_din), .DIN_VALID(b_valid), .DIN_READY(b_ready),
        .OUT_DATA(b_out_data), .OUT_VALID(b_out_valid), .FRAME_START(b_frame_start), .BUSY(b_busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Scoreboard entries are {frame_start, out_data}
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic [1:0] ea, eb;

    task automatic push_frame(input logic [31:0] vec, input int n, input bit to_b);
        for (int i = n - 1; i >= 0; i--) begin
            if (to_b) qb.push_back({(i == n - 1), vec[i]});
            else      qa.push_back({(i == n - 1), vec[i]});
        end
    endtask

    // Monitor A, with a behavioural 1010 detector on the loopback line
    int         det_hits = 0;
    logic [3:0] hist = 4'd0;
    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    chk("a_frame_bit", {30'd0, frame_start, out_data}, {30'd0, ea});
                end
                hist = {hist[2:0], out_data};
                if (hist == 4'b1010) det_hits++;
            end else begin
                chk("a_idle_line", {30'd0, frame_start, out_data}, 32'd0);
                hist = 4'd0;
            end
        end else begin
            hist = 4'd0;
        end
    end

    // Monitor B, also measures the length of each contiguous valid run
    int b_run = 0;
    always @(negedge clk) begin
        if (b_rstn) begin
            if (b_out_valid) begin
                b_run++;
                if (qb.size() == 0) begin
                    chk("b_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    eb = qb.pop_front();
                    chk("b_frame_bit", {30'd0, b_frame_start, b_out_data}, {30'd0, eb});
                end
            end else begin
                if (b_run != 0) chk("b_contig_run", b_run, 32'd24);
                b_run = 0;
                chk("b_idle_line", {30'd0, b_frame_start, b_out_data}, 32'd0);
            end
        end
    end

    task automatic send_a(input logic [7:0] w);
        bit done;
        done = 1'b0;
        din = w;
        din_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (din_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        if (!done) chk("a_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_b(input logic [7:0] w, input bit drop);
        bit done;
        done = 1'b0;
        b_din = w;
        b_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (b_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (drop || !done) b_valid = 1'b0;
        if (!done) chk("b_ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    int det_base;

    initial begin
        rstn = 1'b0; b_rstn = 1'b0;
        din = 8'd0; din_valid = 1'b0; b_din = 8'd0; b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", din_ready, 0);
        chk("reset_outputs", {out_data, out_valid, frame_start, busy}, 0);
        chk("reset_ready_b", b_ready, 0);
        rstn = 1'b1; b_rstn = 1'b1;
        #1;
        chk("ready_before_edge", din_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_release", din_ready, 1);
        chk("busy_after_release", {out_valid, busy}, 0);
        chk("ready_after_release_b", b_ready, 1);
        repeat (2) @(posedge clk);
        #1;

        // 8'hA5: sync, payload, parity 0, then gap and one idle cycle
        push_frame(32'b1010_10100101_0, 13, 1'b0);
        send_a(8'hA5);
        chk("ready_drop_on_accept", din_ready, 0);
        chk("busy_in_frame", busy, 1);
        repeat (13) @(posedge clk);
        #1;
        chk("gap1_state", {out_data, out_valid, busy, din_ready}, 4'b0010);
        @(posedge clk); #1;
        chk("gap2_state", {out_data, out_valid, busy, din_ready}, 4'b0010);
        @(posedge clk); #1;
        chk("idle_after_gap", {out_valid, busy, din_ready}, 3'b001);
        chk("a5_drained", qa.size(), 0);

        // 8'h01: parity bit 1, loopback detector sees exactly one header
        det_base = det_hits;
        push_frame(32'b1010_00000001_1, 13, 1'b0);
        send_a(8'h01);
        repeat (16) @(posedge clk);
        #1;
        chk("p01_drained", qa.size(), 0);
        chk("loopback_sync_detect", det_hits - det_base, 1);

        // 8'h3C offered mid-payload must be ignored
        push_frame(32'b1010_10010110_0, 13, 1'b0);
        send_a(8'h96);
        repeat (6) @(posedge clk);
        #1;
        din = 8'h3C; din_valid = 1'b1;
        chk("ready_low_mid_frame", din_ready, 0);
        @(posedge clk); #1;
        din_valid = 1'b0; din = 8'h00;
        repeat (20) @(posedge clk);
        #1;
        chk("ignore_drained", qa.size(), 0);
        chk("ignore_no_extra_frame", {busy, din_ready}, 2'b01);

        // Async reset during the 6th payload bit
        push_frame(32'b1010_10100101_0, 13, 1'b0);
        send_a(8'hA5);
        repeat (9) @(posedge clk);
        #2;
        rstn = 1'b0;
        qa.delete();
        #1;
        chk("async_reset_outputs", {out_data, out_valid, frame_start, busy, din_ready}, 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        push_frame(32'b1010_10100101_0, 13, 1'b0);
        send_a(8'hA5);
        repeat (16) @(posedge clk);
        #1;
        chk("post_reset_drained", qa.size(), 0);
        chk("post_reset_idle", {busy, din_ready}, 2'b01);

        // Gapless back-to-back: 8'hFF then 8'h00 with valid held high
        push_frame(32'b1010_11111111, 12, 1'b1);
        push_frame(32'b1010_00000000, 12, 1'b1);
        send_b(8'hFF, 1'b0);
        b_din = 8'h00;
        repeat (11) @(posedge clk);
        #1;
        chk("b_ready_last_bit", {b_ready, b_out_valid}, 2'b11);
        send_b(8'h00, 1'b1);
        repeat (14) @(posedge clk);
        #1;
        chk("b_drained", qb.size(), 0);
        chk("b_idle_after", {b_busy, b_ready}, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
